// File: rtl/fft_frame_feeder_pkg.sv
// Shared sizing constants and read-side FSM encoding for the FFT frame feeder.
package fft_frame_feeder_pkg;

    localparam int FRAME_DEPTH  = 256;
    localparam int SAMPLE_WIDTH = 32;
    localparam int PTR_W        = $clog2(FRAME_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_START     = 3'd2,
        ST_FEED      = 3'd3,
        ST_DONE_WAIT = 3'd4
    } rd_state_e;

endpackage

// File: rtl/fft_frame_feeder_if.sv
// Source-side and FFT-core-side signals of the frame feeder; slave is the feeder's view.
interface fft_frame_feeder_if
    import fft_frame_feeder_pkg::*;
#(
    parameter int WIDTH = SAMPLE_WIDTH
);

    logic [WIDTH-1:0] sample_in;
    logic             sample_valid;
    logic             sample_ready;
    logic [WIDTH-1:0] fft_in;
    logic             fft_inc;
    logic             fft_start;
    logic             fft_ready;
    logic             fft_valid;
    logic [15:0]      frames_done;
    logic             busy;

    modport slave (
        input  sample_in, sample_valid, fft_inc, fft_ready, fft_valid,
        output sample_ready, fft_in, fft_start, frames_done, busy
    );

    modport master (
        output sample_in, sample_valid, fft_inc, fft_ready, fft_valid,
        input  sample_ready, fft_in, fft_start, frames_done, busy
    );

endinterface

// File: rtl/fft_frame_feeder_frame_ram.sv
// Simple dual-port frame bank: synchronous write, registered read (1-cycle latency).
module frame_ram
    import fft_frame_feeder_pkg::*;
#(
    parameter int DEPTH = FRAME_DEPTH,
    parameter int WIDTH = SAMPLE_WIDTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_frame_feeder.sv
// Ping-pong frame buffer between a sample stream and an FFT core that pulls words on fft_inc edges.
//   state        | meaning
//   ST_IDLE      | wait for rd_bank full and FFT core idle
//   ST_LOAD      | word 0 of rd_bank captured onto fft_in
//   ST_START     | one-cycle fft_start pulse, word 0 already on fft_in
//   ST_FEED      | advance one word per fft_inc rising edge
//   ST_DONE_WAIT | frame handed over, wait for fft_valid
module fft_frame_feeder
    import fft_frame_feeder_pkg::*;
#(
    parameter int DEPTH = FRAME_DEPTH,
    parameter int WIDTH = SAMPLE_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    fft_frame_feeder_if.slave bus
);

    localparam int            AW   = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    rd_state_e        state_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    rd_addr;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q;
    logic [1:0]       full_q, full_d;
    logic             sample_ready_q;
    logic             fft_start_q;
    logic             busy_q;
    logic             fft_inc_q;
    logic [WIDTH-1:0] fft_in_q;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] rdata [2];
    logic [15:0]      frames_done_q;
    logic             wr_en;
    logic             inc_edge;
    logic             frame_release;

    assign wr_en         = bus.sample_valid & sample_ready_q;
    assign inc_edge      = bus.fft_inc & ~fft_inc_q;
    assign frame_release = (state_q == ST_FEED) && inc_edge && (rd_ptr_q == LAST);
    // Look one word ahead on the edge cycle so fft_in settles two cycles after the edge.
    assign rd_addr       = ((state_q == ST_FEED) && inc_edge) ? rd_ptr_q + AW'(1) : rd_ptr_q;
    assign rd_data       = rdata[rd_bank_q];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        frame_ram #(
            .DEPTH (DEPTH),
            .WIDTH (WIDTH)
        ) u_ram (
            .clk     (clk),
            .we_i    (wr_en && (wr_bank_q == 1'(b))),
            .waddr_i (wr_ptr_q),
            .wdata_i (bus.sample_in),
            .raddr_i (rd_addr),
            .rdata_o (rdata[b])
        );
    end

    // Set and clear can never target the same bank: writes need it empty, release needs it full.
    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        if (wr_en && (wr_ptr_q == LAST)) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
        end
        if (frame_release) begin
            full_d[rd_bank_q] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q       <= '0;
            wr_bank_q      <= 1'b0;
            full_q         <= '0;
            sample_ready_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            wr_bank_q      <= wr_bank_d;
            full_q         <= full_d;
            sample_ready_q <= ~full_d[wr_bank_d];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            rd_ptr_q      <= '0;
            rd_bank_q     <= 1'b0;
            fft_in_q      <= '0;
            fft_start_q   <= 1'b0;
            busy_q        <= 1'b0;
            frames_done_q <= '0;
            fft_inc_q     <= 1'b0;
        end else begin
            fft_inc_q   <= bus.fft_inc;
            fft_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (full_q[rd_bank_q] && bus.fft_ready) begin
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    fft_in_q    <= rd_data;
                    fft_start_q <= 1'b1;
                    busy_q      <= 1'b1;
                    state_q     <= ST_START;
                end
                ST_START: begin
                    state_q <= ST_FEED;
                end
                ST_FEED: begin
                    fft_in_q <= rd_data;
                    if (inc_edge) begin
                        rd_ptr_q <= rd_ptr_q + AW'(1);
                        if (frame_release) begin
                            rd_bank_q     <= ~rd_bank_q;
                            frames_done_q <= frames_done_q + 16'd1;
                            state_q       <= ST_DONE_WAIT;
                        end
                    end
                end
                ST_DONE_WAIT: begin
                    if (bus.fft_valid) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.sample_ready = sample_ready_q;
    assign bus.fft_in       = fft_in_q;
    assign bus.fft_start    = fft_start_q;
    assign bus.busy         = busy_q;
    assign bus.frames_done  = frames_done_q;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Self-checking bench: random/sequential sample streams against a frame-queue model of the feeder.
module tb_fft_frame_feeder;
    import fft_frame_feeder_pkg::*;

    localparam int D = FRAME_DEPTH;
    localparam int W = SAMPLE_WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fft_frame_feeder_if #(.WIDTH(W)) bus ();

    fft_frame_feeder #(
        .DEPTH (D),
        .WIDTH (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: words accepted but not yet presented, plus accepted/released totals since reset.
    logic [W-1:0] exp_q[$];
    int acc_words  = 0;
    int rel_frames = 0;

    int cfg_words, cfg_vprob, cfg_hi, cfg_lo, cfg_ready_at, cfg_valid_wait, cfg_abort_at, cfg_sync_idx;
    bit cfg_seq;
    int cfg_base;
    bit saw_bp;

    task automatic set_cfg(input int words, input bit seq, input int base, input int vprob,
                           input int hi, input int lo, input int ready_at, input int vwait,
                           input int abort_at, input int sync_idx);
        cfg_words = words; cfg_seq = seq; cfg_base = base; cfg_vprob = vprob;
        cfg_hi = hi; cfg_lo = lo; cfg_ready_at = ready_at; cfg_valid_wait = vwait;
        cfg_abort_at = abort_at; cfg_sync_idx = sync_idx;
    endtask

    task automatic run_test(input string name, input int max_cyc, output bit aborted);
        int sent = 0, cyc = 0, edges = 0, phase = 0, since = 0, dw_cnt = 0, fed = 0;
        bit final_now, lat_pending;
        logic [W-1:0] w_exp, w_new;
        aborted     = 1'b0;
        saw_bp      = 1'b0;
        lat_pending = (cfg_ready_at > 0);
        while (1) begin
            @(posedge clk);
            #1;
            cyc++;
            check_eq({name, " ready"}, bus.sample_ready, ((acc_words - rel_frames * D) < 2 * D));
            if (!bus.sample_ready) saw_bp = 1'b1;
            final_now     = 1'b0;
            bus.fft_valid = 1'b0;
            bus.fft_ready = (cyc >= cfg_ready_at);
            w_exp = (exp_q.size() > 0) ? exp_q[0] : 'x;
            case (phase)
                0: begin
                    if (bus.fft_start) begin
                        check_eq({name, " start_full"}, exp_q.size() >= D, 1'b1);
                        check_eq({name, " start_word"}, bus.fft_in, w_exp);
                        check_eq({name, " start_busy"}, bus.busy, 1'b1);
                        if (lat_pending) begin
                            check_eq({name, " start_latency"}, cyc - cfg_ready_at, 2);
                            lat_pending = 1'b0;
                        end
                        phase = 1;
                        edges = 0;
                        since = cfg_hi + cfg_lo - 1;
                    end else begin
                        check_eq({name, " idle_busy"}, bus.busy, 1'b0);
                    end
                end
                1: begin
                    since++;
                    check_eq({name, " feed_start_low"}, bus.fft_start, 1'b0);
                    if (since >= 2) check_eq({name, " feed_word"}, bus.fft_in, w_exp);
                    bus.fft_valid = ($urandom_range(7) == 0);
                    if (cfg_abort_at >= 0 && edges == cfg_abort_at && since >= 2) begin
                        aborted = 1'b1;
                        return;
                    end
                    if (since >= cfg_hi + cfg_lo) begin
                        if (exp_q.size() > 0) void'(exp_q.pop_front());
                        edges++;
                        since       = 0;
                        bus.fft_inc = 1'b1;
                        if (edges == D) begin
                            final_now = 1'b1;
                            rel_frames++;
                            fed++;
                            phase  = 2;
                            dw_cnt = 0;
                        end
                    end else begin
                        bus.fft_inc = (since < cfg_hi);
                    end
                end
                default: begin
                    if (dw_cnt == 0) check_eq({name, " frames_done"}, bus.frames_done, rel_frames[15:0]);
                    check_eq({name, " dw_busy"}, bus.busy, 1'b1);
                    check_eq({name, " dw_start_low"}, bus.fft_start, 1'b0);
                    bus.fft_inc = ~bus.fft_inc;
                    dw_cnt++;
                    if (dw_cnt > cfg_valid_wait) begin
                        bus.fft_valid = 1'b1;
                        bus.fft_inc   = 1'b0;
                        phase         = 0;
                    end
                end
            endcase
            // Source: a word is accepted at the next edge when valid is offered while ready is seen high.
            bus.sample_valid = 1'b0;
            bus.sample_in    = W'($urandom);
            if (sent < cfg_words && $urandom_range(99) < cfg_vprob &&
                !(sent == cfg_sync_idx && !final_now)) begin
                w_new            = cfg_seq ? W'(cfg_base + sent) : W'($urandom);
                bus.sample_valid = 1'b1;
                bus.sample_in    = w_new;
                if (bus.sample_ready) begin
                    exp_q.push_back(w_new);
                    sent++;
                    acc_words++;
                end
            end
            if (sent == cfg_words && fed == cfg_words / D && phase == 0 && !bus.busy) break;
            if (cyc > max_cyc) begin
                check_eq({name, " cycle_budget"}, cyc <= max_cyc, 1'b1);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.fft_valid = 1'b0;
        check_eq({name, " queue_empty"}, exp_q.size(), 0);
        check_eq({name, " frames_total"}, bus.frames_done, rel_frames[15:0]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, " rst_ready"}, bus.sample_ready, 1'b0);
        check_eq({tag, " rst_start"}, bus.fft_start, 1'b0);
        check_eq({tag, " rst_fft_in"}, bus.fft_in, '0);
        check_eq({tag, " rst_busy"}, bus.busy, 1'b0);
        check_eq({tag, " rst_frames"}, bus.frames_done, 16'd0);
    endtask

    task automatic clear_inputs();
        bus.sample_in    = '0;
        bus.sample_valid = 1'b0;
        bus.fft_inc      = 1'b0;
        bus.fft_ready    = 1'b0;
        bus.fft_valid    = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit ab;
        clear_inputs();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("ready_after_reset", bus.sample_ready, 1'b1);

        // one clean frame of 0..255, fastest fft_inc cadence
        set_cfg(256, 1'b1, 0, 100, 1, 1, 0, 3, -1, -1);
        run_test("seq256", 3000, ab);
        // three frames with fft_valid withheld long enough to force backpressure
        set_cfg(768, 1'b1, 0, 100, 1, 1, 0, 600, -1, -1);
        run_test("bp768", 8000, ab);
        check_eq("bp768 backpressure_seen", saw_bp, 1'b1);
        // last write into bank 1 lands on the same edge bank 0 is released
        set_cfg(512, 1'b0, 0, 100, 1, 1, 0, 2, -1, 511);
        run_test("sync", 4000, ab);
        // fft_inc held high three cycles per word with a ragged source
        set_cfg(256, 1'b0, 0, 70, 3, 1, 0, 4, -1, -1);
        run_test("hold3", 4000, ab);
        // frame waits on fft_ready
        set_cfg(256, 1'b0, 0, 100, 1, 2, 400, 2, -1, -1);
        run_test("rdywait", 3000, ab);
        // random mix
        set_cfg(1024, 1'b0, 0, 50, int'($urandom_range(1, 2)), int'($urandom_range(1, 3)), 0, 5, -1, -1);
        run_test("mix", 12000, ab);

        // reset in the middle of feeding word 100
        set_cfg(256, 1'b1, 32'h500, 100, 1, 1, 0, 2, 100, -1);
        run_test("abort", 3000, ab);
        check_eq("abort reached", ab, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("midframe");
        clear_inputs();
        exp_q.delete();
        acc_words  = 0;
        rel_frames = 0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        set_cfg(256, 1'b1, 32'h1000, 100, 1, 1, 0, 2, -1, -1);
        run_test("post_rst", 3000, ab);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
